prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 9 +
 rtl/prog_loader.sv | 143 ++++++++++++++
 tb/tb_prog_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready link between a program source and the loader.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed byte stream into 32-bit instruction
// words, writes them to instruction memory, then releases the RV32I core.
module prog_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      i_stream,
  input  logic              i_reload,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst,
  output logic              o_core_enable,
  output logic              o_done,
  output logic              o_error
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [15:0]      r_count;
  logic [1:0]       r_byte;
  logic [23:0]      r_word;
  logic [CNT_W-1:0] r_widx;

  logic        w_xfer;
  logic        w_word_end;
  logic        w_last_word;
  logic        w_reload_run;
  logic [15:0] w_hdr_count;
  logic        w_in_ready_nxt;
  logic        w_run_nxt;
  logic        w_error_nxt;
  logic        w_we_nxt;

  assign i_stream.in_ready = r_in_ready;
  assign w_xfer       = i_stream.in_valid & r_in_ready;
  assign w_hdr_count  = {i_stream.in_data, r_count[7:0]};
  assign w_word_end   = (r_state == S_LOAD) & w_xfer & (r_byte == 2'd3);
  assign w_last_word  = (32'(r_widx) + 32'd1) == 32'(r_count);
  assign w_reload_run = (r_state == S_RUN) & i_reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_HDR0;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR0: if (w_xfer) w_state_nxt = S_HDR1;
      S_HDR1: begin
        if (w_xfer) begin
          if (w_hdr_count == 16'd0)              w_state_nxt = S_RUN;
          else if (32'(w_hdr_count) > DEPTH)     w_state_nxt = S_ERR;
          else                                   w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: if (w_word_end && w_last_word) w_state_nxt = S_RUN;
      S_RUN:  if (i_reload) w_state_nxt = S_HDR0;
      S_ERR:  w_state_nxt = S_ERR;
      default: w_state_nxt = S_HDR0;
    endcase
  end

  // in_ready tracks the state it enters; core controls trail the state by one cycle
  // so done follows the final write strobe, except that reload drops them at once.
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_run_nxt      = 1'b0;
    w_error_nxt    = 1'b0;
    w_we_nxt       = 1'b0;
    w_in_ready_nxt = (w_state_nxt == S_HDR0) || (w_state_nxt == S_HDR1) ||
                     (w_state_nxt == S_LOAD);
    w_run_nxt      = (r_state == S_RUN) && !i_reload;
    w_error_nxt    = (r_state == S_ERR);
    w_we_nxt       = w_word_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready    <= 1'b1;
      o_imem_we     <= 1'b0;
      o_core_rst    <= 1'b1;
      o_core_enable <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      r_in_ready    <= w_in_ready_nxt;
      o_imem_we     <= w_we_nxt;
      o_core_rst    <= !w_run_nxt;
      o_core_enable <= w_run_nxt;
      o_done        <= w_run_nxt;
      o_error       <= w_error_nxt;
    end
  end

  // Header capture, little-endian word assembly and word index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count      <= 16'd0;
      r_byte       <= 2'd0;
      r_word       <= 24'd0;
      r_widx       <= '0;
      o_imem_addr  <= '0;
      o_imem_wdata <= 32'd0;
    end else if (w_reload_run) begin
      r_count <= 16'd0;
      r_byte  <= 2'd0;
      r_widx  <= '0;
    end else if (w_xfer) begin
      case (r_state)
        S_HDR0: r_count[7:0]  <= i_stream.in_data;
        S_HDR1: r_count[15:8] <= i_stream.in_data;
        S_LOAD: begin
          r_byte <= r_byte + 2'd1;
          case (r_byte)
            2'd0: r_word[7:0]   <= i_stream.in_data;
            2'd1: r_word[15:8]  <= i_stream.in_data;
            2'd2: r_word[23:16] <= i_stream.in_data;
            default: begin
              o_imem_wdata <= {i_stream.in_data, r_word};
              o_imem_addr  <= r_widx[ADDR_W-1:0];
              r_widx       <= r_widx + CNT_W'(1);
            end
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed scoreboard bench for prog_loader: expected imem writes are queued
// as bytes are sent and matched against each write strobe.
module tb_prog_loader;
  localparam int unsigned ADDR_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              reload;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              core_rst;
  logic              core_en;
  logic              done;
  logic              err;

  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_we    = 0;
  int   n_extra = 0;
  wr_t  sb[$];
  logic [31:0] prog[$];
  wr_t  mon_e;

  prog_loader_if bus();

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_stream     (bus),
    .i_reload     (reload),
    .o_imem_we    (we),
    .o_imem_addr  (addr),
    .o_imem_wdata (wdata),
    .o_core_rst   (core_rst),
    .o_core_enable(core_en),
    .o_done       (done),
    .o_error      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      n_we++;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("imem_addr", 64'(addr), 64'(mon_e.addr));
        check("imem_wdata", 64'(wdata), 64'(mon_e.data));
      end else begin
        n_extra++;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hA5;
    for (int g = 0; g < gap; g++) tick(1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) check("send_timeout", 64'(t), 64'd0);
    tick(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_prog(input int gap);
    int          n;
    wr_t         e;
    logic [31:0] wd;
    n = prog.size();
    send_byte(8'(n), gap);
    send_byte(8'(n >> 8), gap);
    for (int w = 0; w < n; w++) begin
      wd     = prog[w];
      e.addr = ADDR_W'(w);
      e.data = wd;
      sb.push_back(e);
      for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8], gap);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
  endtask

  task automatic check_running(input string tag, input int writes);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_core_en"}, 64'(core_en), 64'd1);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_writes"}, 64'(n_we), 64'(writes));
    check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    check({tag, "_extra_we"}, 64'(n_extra), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    reload = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_core_en", 64'(core_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(err), 64'd0);
    tick(2);
    rst = 1'b1;

    // Two words back-to-back; done must trail the last write by one cycle.
    prog = '{32'h0010_0013, 32'h0020_0093};
    n_we = 0;
    run_prog(0);
    check("t1_we_last", 64'(we), 64'd1);
    check("t1_done_lag", 64'(done), 64'd0);
    tick(1);
    check_running("t1", 2);

    // Stream traffic in RUN is ignored.
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    tick(4);
    bus.in_valid = 1'b0;
    check("run_ignore_we", 64'(n_we), 64'd2);
    check("run_ignore_done", 64'(done), 64'd1);

    pulse_reload();
    check("reload_core_en", 64'(core_en), 64'd0);
    check("reload_core_rst", 64'(core_rst), 64'd1);
    check("reload_done", 64'(done), 64'd0);
    check("reload_in_ready", 64'(bus.in_ready), 64'd1);

    // Same program with three idle cycles before every byte.
    n_we = 0;
    run_prog(3);
    tick(1);
    check_running("t2", 2);

    // Reload, then a one-word program lands at index 0.
    pulse_reload();
    prog = '{32'hDEAD_BEEF};
    n_we = 0;
    run_prog(0);
    tick(1);
    check_running("t4", 1);

    // Empty program: straight to RUN, enable two edges after the last header byte.
    pulse_reload();
    prog.delete();
    n_we = 0;
    run_prog(0);
    check("t3_core_en_early", 64'(core_en), 64'd0);
    tick(1);
    check_running("t3", 0);

    // Full capacity: 256 words, last at index 255, no wrap.
    pulse_reload();
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back($urandom());
    n_we = 0;
    run_prog(0);
    check("t7_last_addr", 64'(addr), 64'd255);
    tick(1);
    check_running("t7", 256);

    // Oversized header: N=257 -> terminal error, reload ignored.
    pulse_reload();
    n_we = 0;
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("t5_in_ready", 64'(bus.in_ready), 64'd0);
    tick(1);
    check("t5_error", 64'(err), 64'd1);
    check("t5_core_en", 64'(core_en), 64'd0);
    check("t5_core_rst", 64'(core_rst), 64'd1);
    reload = 1'b1;
    bus.in_valid = 1'b1;
    tick(3);
    reload = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_error_held", 64'(err), 64'd1);
    check("t5_in_ready_held", 64'(bus.in_ready), 64'd0);
    check("t5_no_writes", 64'(n_we), 64'd0);

    rst = 1'b0;
    #1;
    check("t5_rst_error", 64'(err), 64'd0);
    tick(1);
    rst = 1'b1;
    prog = '{32'h1234_5678};
    n_we = 0;
    run_prog(0);
    tick(1);
    check_running("t5_after", 1);

    // Reset mid-word abandons the partial word; a fresh program then loads at 0.
    pulse_reload();
    n_we = 0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_in_ready", 64'(bus.in_ready), 64'd1);
    check("t6_we", 64'(we), 64'd0);
    check("t6_wdata", 64'(wdata), 64'd0);
    check("t6_core_rst", 64'(core_rst), 64'd1);
    check("t6_core_en", 64'(core_en), 64'd0);
    tick(1);
    rst = 1'b1;
    prog = '{32'hCAFE_F00D};
    run_prog(0);
    tick(1);
    check_running("t6", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
